// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared widths and FSM state encoding for the
// modular-exponentiation controller and its multiplier.
package mod_exp_pkg;

    localparam int WIDTH  = 16;
    localparam int PWIDTH = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_MULT,
        S_SQUARE,
        S_DONE
    } state_e;

endpackage

// File: rtl/mod_exp_mul.sv
// mul_16x16: combinational unsigned WIDTH x WIDTH -> PWIDTH multiplier.
// Ports: a_i, b_i operands; p_o full-width product.
module mul_16x16
    import mod_exp_pkg::*;
(
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic [PWIDTH-1:0] p_o
);

    assign p_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

endmodule

// File: rtl/mod_exp.sv
// mod_exp: base^exponent mod modulus by right-to-left square-and-multiply,
// reducing every product through an external remainder unit (mod).
// Ports: clk/rstn; start + base/exponent/modulus request; busy, done,
// result, err status; mod_gen/mod_dividend/mod_divisor to the remainder
// unit and mod_gen_end/mod_res back from it.
module mod_exp
    import mod_exp_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [WIDTH-1:0]  base,
    input  logic [WIDTH-1:0]  exponent,
    input  logic [WIDTH-1:0]  modulus,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              err,
    output logic              mod_gen,
    output logic [PWIDTH-1:0] mod_dividend,
    output logic [PWIDTH-1:0] mod_divisor,
    input  logic              mod_gen_end,
    input  logic [PWIDTH-1:0] mod_res
);

    state_e            state_q;
    state_e            state_d;
    logic [WIDTH-1:0]  b_q, e_q, n_q, acc_q;
    logic [WIDTH-1:0]  b_d, e_d, acc_d;
    logic [WIDTH-1:0]  raw, r, e_sh, fin;
    logic [WIDTH-1:0]  mul_a, mul_b;
    logic [PWIDTH-1:0] prod;
    logic              busy_q, done_q, err_q, gen_q;
    logic [WIDTH-1:0]  result_q;
    logic [PWIDTH-1:0] dvd_q, dvs_q;
    logic              unused_hi;

    // Upper remainder bits are always zero since the divisor fits WIDTH.
    assign unused_hi = ^mod_res[PWIDTH-1:WIDTH];

    // The remainder unit may return n instead of 0; fold that back once.
    assign raw  = mod_res[WIDTH-1:0];
    assign r    = (raw >= n_q) ? raw - n_q : raw;
    assign e_sh = e_q >> 1;

    always_comb begin
        b_d     = r;
        acc_d   = acc_q;
        e_d     = e_q;
        state_d = S_IDLE;
        unique case (state_q)
            S_REDUCE: begin
                if (e_q == '0)
                    state_d = S_DONE;
                else if (e_q[0])
                    state_d = S_MULT;
                else
                    state_d = S_SQUARE;
            end
            S_MULT: begin
                b_d     = b_q;
                acc_d   = r;
                state_d = (e_sh == '0) ? S_DONE : S_SQUARE;
            end
            S_SQUARE: begin
                e_d     = e_sh;
                state_d = e_sh[0] ? S_MULT : S_SQUARE;
            end
            default: begin
                b_d = b_q;
            end
        endcase
    end

    // One multiplier shared by acc*b and b*b, fed with post-capture values
    // so the next request's dividend is ready on the capture edge.
    assign mul_a = (state_d == S_MULT) ? acc_d : b_d;
    assign mul_b = b_d;
    assign fin   = (n_q == WIDTH'(1)) ? '0 : acc_d;

    mul_16x16 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            gen_q    <= 1'b0;
            result_q <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
        end else begin
            gen_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        b_q   <= base;
                        e_q   <= exponent;
                        n_q   <= modulus;
                        acc_q <= WIDTH'(1);
                        dvs_q <= {{WIDTH{1'b0}}, modulus};
                        if (modulus == '0) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            gen_q   <= 1'b1;
                            dvd_q   <= {{WIDTH{1'b0}}, base};
                            state_q <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE, S_MULT, S_SQUARE: begin
                    if (mod_gen_end) begin
                        b_q     <= b_d;
                        e_q     <= e_d;
                        acc_q   <= acc_d;
                        state_q <= state_d;
                        if (state_d == S_DONE) begin
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            err_q    <= 1'b0;
                            result_q <= fin;
                        end else begin
                            gen_q <= 1'b1;
                            dvd_q <= prod;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign err          = err_q;
    assign mod_gen      = gen_q;
    assign mod_dividend = dvd_q;
    assign mod_divisor  = dvs_q;

endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: directed and random checks of mod_exp against a plain
// arithmetic golden model, with a behavioural remainder unit attached.
module tb_mod_exp;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] base, exponent, modulus;
    logic        busy, done, err, mod_gen, mod_gen_end;
    logic [15:0] result;
    logic [31:0] mod_dividend, mod_divisor, mod_res;

    int ntest = 0;
    int nfail = 0;

    // remainder-unit model configuration and bookkeeping
    int          lat_lo = 33;
    int          lat_hi = 33;
    bit          quirk  = 0;
    int          gen_cnt = 0;
    int          proto_err = 0;
    bit          m_busy = 0;
    int          m_cnt = 0;
    logic [31:0] m_dvd, m_dvs, m_ans;

    mod_exp dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .base         (base),
        .exponent     (exponent),
        .modulus      (modulus),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .err          (err),
        .mod_gen      (mod_gen),
        .mod_dividend (mod_dividend),
        .mod_divisor  (mod_divisor),
        .mod_gen_end  (mod_gen_end),
        .mod_res      (mod_res)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural remainder unit: answers L cycles after each request.
    always @(negedge clk) begin
        mod_gen_end = 1'b0;
        if (m_busy) begin
            if (rstn && busy &&
                (mod_dividend !== m_dvd || mod_divisor !== m_dvs))
                proto_err++;
            m_cnt--;
            if (m_cnt <= 0) begin
                mod_gen_end = 1'b1;
                mod_res     = m_ans;
                m_busy      = 0;
            end
        end
        if (mod_gen === 1'b1) begin
            gen_cnt++;
            if (m_busy) proto_err++;
            m_dvd = mod_dividend;
            m_dvs = mod_divisor;
            if (m_dvs == 0)
                m_ans = 0;
            else
                m_ans = m_dvd % m_dvs;
            if (quirk && m_ans == 0)
                m_ans = m_dvs;
            m_cnt  = $urandom_range(lat_hi, lat_lo);
            m_busy = 1;
        end
    end

    function automatic logic [15:0] golden(input int unsigned b,
                                           input int unsigned e,
                                           input int unsigned n);
        longint unsigned acc, bb;
        int unsigned     x;
        if (n == 0) return 16'd0;
        acc = 1 % n;
        bb  = b % n;
        x   = e;
        while (x != 0) begin
            if (x[0]) acc = (acc * bb) % n;
            bb = (bb * bb) % n;
            x  = x >> 1;
        end
        return 16'(acc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [15:0] b, input logic [15:0] e,
                           input logic [15:0] n, input int poke,
                           output logic [15:0] res, output logic er,
                           output int dc, output logic bok);
        bok = 1;
        dc  = -1;
        res = '0;
        er  = 0;
        @(negedge clk);
        start    = 1;
        base     = b;
        exponent = e;
        modulus  = n;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            start = (k == poke);
            if (k == poke) begin
                base     = ~b;
                exponent = e + 16'd3;
                modulus  = n ^ 16'h0055;
            end
            if (done) begin
                dc  = k;
                res = result;
                er  = err;
                if (busy) bok = 0;
                break;
            end
            if (!busy) bok = 0;
        end
        @(negedge clk);
        start = 0;
        if (done) bok = 0;
    endtask

    logic [15:0] res;
    logic        er, bok, spur;
    int          dc, g0;
    logic [15:0] rb, re, rn;
    logic [16:0] msk;

    initial begin
        rstn = 0;
        start = 0;
        base = 0;
        exponent = 0;
        modulus = 0;
        mod_gen_end = 0;
        mod_res = 0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_err", 32'(err), 0);
        check("rst_gen", 32'(mod_gen), 0);
        check("rst_dvd", mod_dividend, 0);
        check("rst_dvs", mod_divisor, 0);
        repeat (3) @(negedge clk);
        rstn = 1;

        // fixed latency 33 -> 34 cycles per request
        run_job(16'd4, 16'd13, 16'd497, -1, res, er, dc, bok);
        check("e13_res", 32'(res), 445);
        check("e13_err", 32'(er), 0);
        check("e13_cyc", 32'(dc), 239);
        check("e13_busy", 32'(bok), 1);

        run_job(16'd3, 16'd0, 16'd7, -1, res, er, dc, bok);
        check("e0_res", 32'(res), 1);
        check("e0_cyc", 32'(dc), 35);
        run_job(16'd3, 16'd0, 16'd1, -1, res, er, dc, bok);
        check("e0n1_res", 32'(res), 0);
        check("e0n1_cyc", 32'(dc), 35);

        quirk = 1;
        run_job(16'd3, 16'd2, 16'd9, -1, res, er, dc, bok);
        check("quirk_res", 32'(res), 0);
        check("quirk_cyc", 32'(dc), 103);
        quirk = 0;

        g0 = gen_cnt;
        run_job(16'd5, 16'd3, 16'd0, -1, res, er, dc, bok);
        check("n0_cyc", 32'(dc), 1);
        check("n0_err", 32'(er), 1);
        check("n0_res", 32'(res), 0);
        check("n0_nogen", 32'(gen_cnt - g0), 0);
        check("n0_busy", 32'(bok), 1);

        run_job(16'd4, 16'd13, 16'd497, 50, res, er, dc, bok);
        check("poke_res", 32'(res), 445);
        check("poke_cyc", 32'(dc), 239);
        check("poke_err", 32'(er), 0);

        // reset 10 cycles into a job
        @(negedge clk);
        start = 1;
        base = 16'd4;
        exponent = 16'd13;
        modulus = 16'd497;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rstn = 0;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_gen", 32'(mod_gen), 0);
        check("mid_dvd", mod_dividend, 0);
        check("mid_dvs", mod_divisor, 0);
        check("mid_out", {29'd0, done, err, |result}, 0);
        repeat (2) @(negedge clk);
        rstn = 1;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || mod_gen) spur = 1;
        end
        check("stale_ignored", 32'(spur), 0);
        run_job(16'd2, 16'd10, 16'd1000, -1, res, er, dc, bok);
        check("post_rst_res", 32'(res), 24);
        check("post_rst_cyc", 32'(dc), 205);

        // random operands, random remainder-unit latency
        for (int j = 0; j < 1000; j++) begin
            if ($urandom_range(9, 0) == 0) begin
                lat_lo = 1;
                lat_hi = 40;
            end else begin
                lat_lo = 1;
                lat_hi = 2;
            end
            quirk = $urandom_range(1, 0) == 1;
            msk = (17'd1 << $urandom_range(16, 0)) - 17'd1;
            rb  = 16'($urandom);
            re  = 16'($urandom) & msk[15:0];
            if ($urandom_range(1, 0) == 1)
                rn = 16'($urandom);
            else
                rn = 16'($urandom_range(20, 0));
            run_job(rb, re, rn, -1, res, er, dc, bok);
            check($sformatf("rnd%0d_res", j), 32'(res),
                  32'(golden(rb, re, rn)));
            check($sformatf("rnd%0d_err", j), 32'(er),
                  32'(rn == 0));
        end

        check("protocol", 32'(proto_err), 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
